instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning instruction-queue entries (power of 2, >=2).
REQ-002 SHALL have parameter HALT_OP, default 0, meaning opcode value that stops fetching.
REQ-003 SHALL have port clk  input  1  meaning the single rising-edge clock.
REQ-004 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-005 SHALL have port mem_rd  output  1  meaning byte read request to program RAM.
REQ-006 SHALL have port mem_addr  output  8  meaning byte address of the request.
REQ-007 SHALL have port mem_rdata  input  8  meaning read data, valid exactly 1 cycle after mem_rd.
REQ-008 SHALL have port instr_valid  output  1  meaning the queue head holds an instruction.
REQ-009 SHALL have port instr_ready  input  1  meaning the downstream executor accepts the head.
REQ-010 SHALL have port instr_opcode  output  8  meaning byte 0 of the head instruction.
REQ-011 SHALL have port instr_reg  output  8  meaning byte 1 (register address).
REQ-012 SHALL have port instr_addr  output  16  meaning {byte 3, byte 2} (operand/address).
REQ-013 SHALL have port instr_pc  output  8  meaning byte address of byte 0 of the head.
REQ-014 SHALL have port redirect  input  1  meaning flush and restart fetch.
REQ-015 SHALL have port redirect_pc  input  8  meaning new fetch address when redirect is high.
REQ-016 SHALL have port halted  output  1  meaning fetch stopped on HALT_OP.

Function
REQ-017 SHALL fetch one 4-byte instruction at a time: mem_rd high for 4 consecutive cycles, addresses pc, pc+1, pc+2, pc+3, all mod 256.
REQ-018 SHALL capture mem_rdata one cycle after each request; byte k fills field k.
REQ-019 SHALL push the assembled instruction with its pc in the cycle byte 3 is captured; instr_valid visible the following cycle (first instr_valid 6 cycles after reset release with empty queue).
REQ-020 SHALL advance pc by 4 (mod 256) on each push.
REQ-021 SHALL issue byte 0 only when queued count plus in-flight instructions is below DEPTH, counting a same-cycle pop as freeing an entry.
REQ-022 SHALL allow byte 0 of the next instruction in the same cycle byte 3 of the previous is captured (peak 1 instruction per 4 cycles).
REQ-023 SHALL pop the head on a cycle with instr_valid and instr_ready both high; head fields hold stable while instr_valid is high and instr_ready is low.
REQ-024 SHALL use FSM states FETCH (issuing/collecting bytes), WAIT (queue full, mem_rd low), HALTED (mem_rd low, halted high).
REQ-025 SHALL enter HALTED when an instruction with opcode HALT_OP is pushed; that instruction is still queued and delivered.
REQ-026 SHALL, on redirect, empty the queue, abandon the in-flight instruction, set pc to redirect_pc, leave HALTED, and resume FETCH the next cycle.
REQ-027 SHALL give redirect priority over a same-cycle pop or push (both discarded); instr_valid low the cycle after.
REQ-028 SHALL discard mem_rdata returning in the cycle after redirect (belongs to abandoned read).
REQ-029 SHALL never push to a full queue nor pop an empty one; instr_ready with instr_valid low is ignored.

Reset
REQ-030 SHALL on reset low asynchronously set pc=0, queue empty, state FETCH, mem_rd=0, mem_addr=0, instr_valid=0, instr_opcode=0, instr_reg=0, instr_addr=0, instr_pc=0, halted=0.
REQ-031 SHALL start fetching at address 0 on the first clk edge after reset deasserts; reset mid-fetch discards partial bytes.

Structure
REQ-032 SHALL take opcode constants (mov-const 1, load 2, store 3, add 4, HALT_OP 0), field widths and the instruction record typedef {opcode, reg, addr, pc} from the shared CPU package.
REQ-033 SHALL implement the queue as sub-module instr_fifo (DEPTH entries, push/pop/full/empty/count, flush input).

Verification
REQ-034 RAM bytes 0..7 = 1,2,0x34,0x12,4,0,1,0, instr_ready=1 -> head 1 at cycle 6: opcode 1, reg 2, addr 0x1234, pc 0; head 2: opcode 4, pc 4.
REQ-035 instr_ready=0, DEPTH=2 -> exactly 2 instructions queued, mem_rd low (WAIT) until a pop, then refetch at pc 8.
REQ-036 RAM byte 8 = HALT_OP -> instruction at pc 8 delivered, halted=1, mem_rd stays 0 for 20 cycles.
REQ-037 redirect=1, redirect_pc=0x40 during byte 2 fetch -> queue empty next cycle, next mem_addr 0x40, no instruction with pc of abandoned fetch ever appears.
REQ-038 pc=0xFC -> mem_addr 0xFC,0xFD,0xFE,0xFF; next instruction pc 0x00.
REQ-039 reset low mid-fetch with queue non-empty -> all outputs at reset values immediately (before next clk edge); refetch from 0 after release.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions: opcode constants, instruction field widths,
// the queued instruction record and the fetch FSM state encoding.
package instr_fetch_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned OPC_W       = 8;
  localparam int unsigned REG_W       = 8;
  localparam int unsigned OPND_W      = 16;
  localparam int unsigned PC_W        = 8;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [OPC_W-1:0] OP_HALT      = 8'h00;
  localparam logic [OPC_W-1:0] OP_MOV_CONST = 8'h01;
  localparam logic [OPC_W-1:0] OP_LOAD      = 8'h02;
  localparam logic [OPC_W-1:0] OP_STORE     = 8'h03;
  localparam logic [OPC_W-1:0] OP_ADD       = 8'h04;

  // One decoded instruction plus the address of its first byte
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_W-1:0]  reg_addr;
    logic [OPND_W-1:0] addr;
    logic [PC_W-1:0]   pc;
  } instr_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Instruction queue: DEPTH-entry circular buffer of instr_t records.
// Ports: clk, reset (async active-low), flush (empties queue, wins over
// push/pop), push/push_data, pop, head (oldest entry), full, empty, count.
module instr_fifo
  import instr_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  instr_t                     push_data,
  input  logic                       pop,
  output instr_t                     head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  instr_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            do_push;
  logic            do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage is cleared on reset so the head fields read zero out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads 4-byte instructions from a byte-wide program
// RAM (1-cycle read latency), assembles them and queues them for the executor.
// Ports: clk, reset (async active-low); mem_rd/mem_addr/mem_rdata RAM port;
// instr_valid/instr_ready handshake with instr_opcode/reg/addr/pc head fields;
// redirect/redirect_pc flush-and-restart; halted after a HALT_OP push.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned      DEPTH   = 2,
  parameter logic [OPC_W-1:0] HALT_OP = OP_HALT
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_rd,
  output logic [PC_W-1:0]   mem_addr,
  input  logic [BYTE_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [OPC_W-1:0]  instr_opcode,
  output logic [REG_W-1:0]  instr_reg,
  output logic [OPND_W-1:0] instr_addr,
  output logic [PC_W-1:0]   instr_pc,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              halted
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W = $clog2(INSTR_BYTES);

  fetch_state_t       state;
  logic [IDX_W-1:0]   nidx;       // byte index of the next request to issue
  logic [IDX_W-1:0]   mem_idx;    // byte index of the request on mem_addr
  logic [PC_W-1:0]    iss_addr;   // address of the next request to issue
  logic [PC_W-1:0]    pc;         // pc of the instruction being assembled
  logic [1:0]         inflight;   // instructions with byte 0 issued, not yet pushed
  logic               cap_vld;    // mem_rdata this cycle answers one of our reads
  logic [IDX_W-1:0]   cap_idx;
  logic [BYTE_W-1:0]  b0, b1, b2;

  instr_t             push_rec;
  instr_t             head;
  logic               fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               push_c, pop_c, halt_c, room_c, issue_c, issue0_c;

  assign push_rec = '{opcode: b0, reg_addr: b1, addr: {mem_rdata, b2}, pc: pc};
  assign push_c   = cap_vld & (cap_idx == IDX_W'(INSTR_BYTES - 1)) & ~redirect & ~fifo_full;
  assign pop_c    = ~fifo_empty & instr_ready & ~redirect;
  assign halt_c   = push_c & (b0 == HALT_OP);
  // A same-cycle pop frees an entry for the new instruction
  assign room_c   = (32'(fifo_count) + 32'(inflight)) < (DEPTH + 32'(pop_c));

  // Decide whether a RAM request goes out next cycle (redirect/halt handled in the register block)
  always_comb begin
    issue_c  = 1'b0;
    issue0_c = 1'b0;
    if (!redirect && !halt_c) begin
      case (state)
        FETCH: begin
          if (nidx != '0) begin
            issue_c = 1'b1;
          end else if (room_c) begin
            issue_c  = 1'b1;
            issue0_c = 1'b1;
          end
        end
        WAIT: begin
          if (room_c) begin
            issue_c  = 1'b1;
            issue0_c = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Fetch FSM, request generation and byte assembly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= FETCH;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      mem_idx  <= '0;
      nidx     <= '0;
      iss_addr <= '0;
      pc       <= '0;
      inflight <= '0;
      cap_vld  <= 1'b0;
      cap_idx  <= '0;
      b0       <= '0;
      b1       <= '0;
      b2       <= '0;
      halted   <= 1'b0;
    end else begin
      // Data returning after a redirect or halt belongs to an abandoned read
      cap_vld <= mem_rd & ~redirect & ~halt_c;
      cap_idx <= mem_idx;

      if (cap_vld && !redirect) begin
        case (cap_idx)
          IDX_W'(0): b0 <= mem_rdata;
          IDX_W'(1): b1 <= mem_rdata;
          IDX_W'(2): b2 <= mem_rdata;
          default: ;
        endcase
      end

      if (redirect) begin
        // Restart at redirect_pc with byte 0 going out immediately
        state    <= FETCH;
        halted   <= 1'b0;
        pc       <= redirect_pc;
        mem_rd   <= 1'b1;
        mem_addr <= redirect_pc;
        mem_idx  <= '0;
        nidx     <= IDX_W'(1);
        iss_addr <= redirect_pc + PC_W'(1);
        inflight <= 2'd1;
      end else if (halt_c) begin
        // Any next instruction already started is dropped
        state    <= HALTED;
        halted   <= 1'b1;
        pc       <= pc + PC_W'(INSTR_BYTES);
        mem_rd   <= 1'b0;
        nidx     <= '0;
        inflight <= '0;
      end else begin
        if (push_c) pc <= pc + PC_W'(INSTR_BYTES);
        mem_rd   <= issue_c;
        inflight <= inflight + 2'(issue0_c) - 2'(push_c);
        if (issue_c) begin
          mem_addr <= iss_addr;
          mem_idx  <= nidx;
          nidx     <= nidx + IDX_W'(1);
          iss_addr <= iss_addr + PC_W'(1);
        end
        case (state)
          FETCH:   if (!issue_c) state <= WAIT;
          WAIT:    if (issue_c) state <= FETCH;
          default: ;
        endcase
      end
    end
  end

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push_c),
    .push_data (push_rec),
    .pop       (pop_c),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign instr_valid  = ~fifo_empty;
  assign instr_opcode = head.opcode;
  assign instr_reg    = head.reg_addr;
  assign instr_addr   = head.addr;
  assign instr_pc     = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [7:0]  instr_opcode;
  logic [7:0]  instr_reg;
  logic [15:0] instr_addr;
  logic [7:0]  instr_pc;
  logic        redirect = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        halted;

  int checks = 0;
  int failures = 0;

  logic [7:0] ram [256];

  instr_fetch #(.DEPTH(2), .HALT_OP(8'h00)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_reg    (instr_reg),
    .instr_addr   (instr_addr),
    .instr_pc     (instr_pc),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  // Program RAM: data for the address presented in one cycle appears the next
  always @(posedge clk) mem_rdata <= ram[mem_addr];

  // Reference: the instruction whose first byte sits at p
  function automatic logic [39:0] exp_instr(input logic [7:0] p);
    logic [7:0] p1, p2, p3;
    p1 = p + 8'd1;
    p2 = p + 8'd2;
    p3 = p + 8'd3;
    return {ram[p], ram[p1], ram[p3], ram[p2], p};
  endfunction

  function automatic logic [39:0] head_bits();
    return {instr_opcode, instr_reg, instr_addr, instr_pc};
  endfunction

  task automatic fill_ram_nonzero();
    for (int i = 0; i < 256; i++) ram[i] = 8'($urandom_range(1, 255));
  endtask

  task automatic load_prog();
    logic [7:0] prog [8];
    prog = '{8'd1, 8'd2, 8'h34, 8'h12, 8'd4, 8'd0, 8'd1, 8'd0};
    for (int i = 0; i < 8; i++) ram[i] = prog[i];
  endtask

  // Leaves reset released at a falling edge; the next rising edge is the first fetch edge
  task automatic do_reset();
    reset = 1'b0;
    instr_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_rd !== 1'b0 || mem_addr !== 8'h00) begin
      failures++;
      $display("FAIL reset_mem: mem_rd=%b mem_addr=%h expected 0/00", mem_rd, mem_addr);
    end
    checks++;
    if (instr_valid !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: valid=%b halted=%b expected 0/0", instr_valid, halted);
    end
    checks++;
    if (head_bits() !== 40'h0) begin
      failures++;
      $display("FAIL reset_fields: got %h expected 0", head_bits());
    end
  endtask

  task automatic test_basic();
    int first;
    fill_ram_nonzero();
    load_prog();
    do_reset();
    instr_ready = 1'b1;
    first = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (instr_valid === 1'b1 && first < 0) begin
        first = c;
        checks++;
        if (head_bits() !== {8'd1, 8'd2, 16'h1234, 8'h00}) begin
          failures++;
          $display("FAIL basic_head1: got %h expected %h", head_bits(), {8'd1, 8'd2, 16'h1234, 8'h00});
        end
      end
      if (c == 10) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_opcode !== 8'd4 || instr_pc !== 8'd4) begin
          failures++;
          $display("FAIL basic_head2: valid=%b opcode=%h pc=%h expected 1/04/04",
                   instr_valid, instr_opcode, instr_pc);
        end
      end
    end
    checks++;
    if (first != 6) begin
      failures++;
      $display("FAIL basic_latency: first valid at cycle %0d expected 6", first);
    end
  endtask

  task automatic test_wait();
    int rd_cnt;
    fill_ram_nonzero();
    do_reset();
    rd_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_rd === 1'b1) rd_cnt++;
    end
    checks++;
    if (rd_cnt != 8 || mem_rd !== 1'b0) begin
      failures++;
      $display("FAIL wait_stall: read cycles=%0d mem_rd=%b expected 8/0", rd_cnt, mem_rd);
    end
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 8'h00) begin
      failures++;
      $display("FAIL wait_head: valid=%b pc=%h expected 1/00", instr_valid, instr_pc);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 8'h08) begin
      failures++;
      $display("FAIL wait_refetch: mem_rd=%b mem_addr=%h expected 1/08", mem_rd, mem_addr);
    end
  endtask

  task automatic test_halt();
    int accepted, rd_while_halted, halted_cycles;
    logic [7:0] last_pc, last_op;
    fill_ram_nonzero();
    load_prog();
    ram[8] = 8'h00;
    do_reset();
    instr_ready = 1'b1;
    accepted = 0;
    rd_while_halted = 0;
    halted_cycles = 0;
    last_pc = 8'hxx;
    last_op = 8'hxx;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (instr_valid === 1'b1) begin
        accepted++;
        last_pc = instr_pc;
        last_op = instr_opcode;
      end
      if (halted === 1'b1) begin
        halted_cycles++;
        if (mem_rd !== 1'b0) rd_while_halted++;
      end
    end
    checks++;
    if (accepted != 3 || last_pc !== 8'h08 || last_op !== 8'h00) begin
      failures++;
      $display("FAIL halt_delivery: count=%0d last_pc=%h last_op=%h expected 3/08/00",
               accepted, last_pc, last_op);
    end
    checks++;
    if (halted !== 1'b1 || halted_cycles < 20 || rd_while_halted != 0) begin
      failures++;
      $display("FAIL halt_stop: halted=%b halted_cycles=%0d reads=%0d expected 1/>=20/0",
               halted, halted_cycles, rd_while_halted);
    end
  endtask

  task automatic test_redirect();
    int tmo, bad;
    logic [7:0] exp_pc;
    fill_ram_nonzero();
    do_reset();
    tmo = 0;
    do begin
      @(negedge clk);
      tmo++;
    end while (!(mem_rd === 1'b1 && mem_addr === 8'h06) && tmo < 50);
    checks++;
    if (tmo >= 50 || instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL redirect_setup: cycles=%0d valid=%b expected addr 06 seen with queue non-empty",
               tmo, instr_valid);
    end
    redirect = 1'b1;
    redirect_pc = 8'h40;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 8'h40) begin
      failures++;
      $display("FAIL redirect_flush: valid=%b mem_rd=%b mem_addr=%h expected 0/1/40",
               instr_valid, mem_rd, mem_addr);
    end
    instr_ready = 1'b1;
    exp_pc = 8'h40;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (instr_valid === 1'b1) begin
        if (head_bits() !== exp_instr(exp_pc)) bad++;
        exp_pc = exp_pc + 8'd4;
      end
    end
    checks++;
    if (bad != 0 || exp_pc == 8'h40) begin
      failures++;
      $display("FAIL redirect_stream: wrong=%0d next_pc=%h expected 0 wrong from pc 40", bad, exp_pc);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_addr [5];
    logic [7:0] a;
    logic [7:0] pcs [2];
    int n;
    exp_addr = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00};
    fill_ram_nonzero();
    do_reset();
    repeat (2) @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 8'hFC;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      redirect = 1'b0;
      a = exp_addr[k];
      checks++;
      if (mem_rd !== 1'b1 || mem_addr !== a) begin
        failures++;
        $display("FAIL wrap_addr%0d: mem_rd=%b mem_addr=%h expected 1/%h", k, mem_rd, mem_addr, a);
      end
    end
    instr_ready = 1'b1;
    n = 0;
    pcs = '{8'hxx, 8'hxx};
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (instr_valid === 1'b1 && n < 2) begin
        pcs[n] = instr_pc;
        n++;
      end
    end
    checks++;
    if (n != 2 || pcs[0] !== 8'hFC || pcs[1] !== 8'h00) begin
      failures++;
      $display("FAIL wrap_pc: n=%0d pcs=%h,%h expected FC,00", n, pcs[0], pcs[1]);
    end
  endtask

  task automatic test_async_reset();
    int first;
    fill_ram_nonzero();
    do_reset();
    repeat (7) @(negedge clk);
    checks++;
    if (instr_valid !== 1'b1 || mem_rd !== 1'b1) begin
      failures++;
      $display("FAIL areset_setup: valid=%b mem_rd=%b expected 1/1", instr_valid, mem_rd);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mem_rd !== 1'b0 || mem_addr !== 8'h00 || instr_valid !== 1'b0 || halted !== 1'b0 ||
        head_bits() !== 40'h0) begin
      failures++;
      $display("FAIL areset_outputs: mem_rd=%b addr=%h valid=%b halted=%b fields=%h expected all 0",
               mem_rd, mem_addr, instr_valid, halted, head_bits());
    end
    @(negedge clk);
    reset = 1'b1;
    instr_ready = 1'b1;
    first = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 8'h00) begin
          failures++;
          $display("FAIL areset_refetch: mem_rd=%b mem_addr=%h expected 1/00", mem_rd, mem_addr);
        end
      end
      if (instr_valid === 1'b1 && first < 0) begin
        first = c;
        checks++;
        if (head_bits() !== exp_instr(8'h00)) begin
          failures++;
          $display("FAIL areset_head: got %h expected %h", head_bits(), exp_instr(8'h00));
        end
      end
    end
    checks++;
    if (first != 6) begin
      failures++;
      $display("FAIL areset_latency: first valid at cycle %0d expected 6", first);
    end
  endtask

  task automatic test_random();
    logic [7:0]  exp_pc, rp;
    logic [39:0] held_v, e;
    logic        held, rd, redir;
    int          accepted;
    fill_ram_nonzero();
    do_reset();
    exp_pc = 8'h00;
    held = 1'b0;
    held_v = '0;
    accepted = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (held) begin
        checks++;
        if (instr_valid !== 1'b1 || head_bits() !== held_v) begin
          failures++;
          $display("FAIL rand_hold cyc %0d: valid=%b got %h expected %h", c, instr_valid, head_bits(), held_v);
        end
      end
      rd = ($urandom_range(0, 2) != 0);
      redir = ($urandom_range(0, 49) == 0);
      rp = 8'($urandom);
      if (instr_valid === 1'b1 && rd && !redir) begin
        e = exp_instr(exp_pc);
        checks++;
        accepted++;
        if (head_bits() !== e) begin
          failures++;
          $display("FAIL rand_instr cyc %0d: got %h expected %h", c, head_bits(), e);
        end
        exp_pc = exp_pc + 8'd4;
      end
      held = (instr_valid === 1'b1) && !rd && !redir;
      held_v = head_bits();
      if (redir) exp_pc = rp;
      instr_ready = rd;
      redirect = redir;
      redirect_pc = rp;
    end
    redirect = 1'b0;
    checks++;
    if (accepted < 50) begin
      failures++;
      $display("FAIL rand_progress: accepted %0d expected at least 50", accepted);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wait();
    test_halt();
    test_redirect();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
